// File: rtl/sprite_dma_copier.sv
// rtl/sprite_dma_copier.sv - block-RAM to block-RAM word copier, one word per clock
// Optional source clear after copy: define SPRITE_DMA_CLEAR_EN.
module sprite_dma_copier #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int COUNT  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_q,
    output logic              src_wren,
    output logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wren
);

    // Pointers carry one extra bit so COUNT == 2**ADDR_W is representable.
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] LAST = PW'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COPY  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic              rd_active_q, rd_active_d;
    logic              rd_valid_q, rd_valid_d;
    logic [PW-1:0]     rd_next;

    assign rd_next = rd_ptr_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            src_addr_q  <= '0;
            dst_base_q  <= '0;
            rd_active_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            src_addr_q  <= src_addr_d;
            dst_base_q  <= dst_base_d;
            rd_active_q <= rd_active_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        src_addr_d  = src_addr_q;
        dst_base_d  = dst_base_q;
        rd_active_d = rd_active_q;
        rd_valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_COPY;
                    dst_base_d  = dst_base;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    src_addr_d  = '0;
                    rd_active_d = 1'b1;
                end
            end
            S_COPY: begin
                // rd_active means src_addr holds a read the RAM samples this edge.
                rd_valid_d = rd_active_q;
                if (rd_active_q) begin
                    if (rd_ptr_q != LAST) begin
                        rd_ptr_d   = rd_next;
                        src_addr_d = rd_next[ADDR_W-1:0];
                    end else begin
                        rd_active_d = 1'b0;
                    end
                end
                if (rd_valid_q) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST) begin
                        rd_valid_d = 1'b0;
`ifdef SPRITE_DMA_CLEAR_EN
                        state_d    = S_CLEAR;
                        rd_ptr_d   = '0;
                        src_addr_d = '0;
`else
                        state_d    = S_DONE;
`endif
                    end
                end
            end
            S_CLEAR: begin
                if (rd_ptr_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    rd_ptr_d   = rd_next;
                    src_addr_d = rd_next[ADDR_W-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == S_COPY) || (state_q == S_CLEAR);
    assign done     = (state_q == S_DONE);
    assign src_addr = src_addr_q;
    assign dst_wren = (state_q == S_COPY) && rd_valid_q;
    // Read data goes straight to the write port; gated so it is 0 when idle.
    assign dst_data = dst_wren ? src_q : '0;
    assign dst_addr = dst_base_q + wr_ptr_q[ADDR_W-1:0];

`ifdef SPRITE_DMA_CLEAR_EN
    assign src_wren = (state_q == S_CLEAR);
`else
    assign src_wren = 1'b0;
`endif
    assign src_data = '0;

endmodule

// File: tb/tb_sprite_dma_copier.sv
// tb/tb_sprite_dma_copier.sv - self-checking bench for sprite_dma_copier (COUNT=4 and COUNT=1 instances)
module tb_sprite_dma_copier;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       start = '0;
    logic [1:0][9:0]  dst_base_in = '0;
    logic [1:0]       busy, done, src_wren, dst_wren;
    logic [1:0][9:0]  src_addr, dst_addr;
    logic [1:0][15:0] src_q, src_data, dst_data;

    logic [15:0] src_mem [2][1024];
    logic [25:0] wlog[$];
    logic [25:0] clog[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sprite_dma_copier #(.DATA_W(16), .ADDR_W(10), .COUNT(g == 0 ? 4 : 1)) u_dut (
            .clk      (clk),
            .reset    (rst),
            .start    (start[g]),
            .dst_base (dst_base_in[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .src_addr (src_addr[g]),
            .src_q    (src_q[g]),
            .src_wren (src_wren[g]),
            .src_data (src_data[g]),
            .dst_addr (dst_addr[g]),
            .dst_data (dst_data[g]),
            .dst_wren (dst_wren[g])
        );
    end

    // Source RAM read port (registered) and logs of every write that lands on an edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            src_q[i] <= src_mem[i][src_addr[i]];
            if (!rst && dst_wren[i]) wlog.push_back({dst_addr[i], dst_data[i]});
            if (!rst && src_wren[i]) clog.push_back({src_addr[i], src_data[i]});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clr_extra(input int n);
`ifdef SPRITE_DMA_CLEAR_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    typedef struct {
        int         sel;
        logic [9:0] base;
        int         pattern;
        logic [9:0] exp_first;
        logic [9:0] exp_last;
        int         exp_busy;
    } vec_t;

    task automatic xfer(input int sel, input logic [9:0] base, input int pattern,
                        input logic [9:0] exp_first, input logic [9:0] exp_last, input int exp_busy);
        int n = (sel == 0) ? 4 : 1;
        logic [15:0] exp_d[$];
        int w0 = wlog.size();
        int c0 = clog.size();
        int nb = 0, nd = 0, last_busy = -1, done_at = -1, stray = 0;
        for (int k = 0; k < n; k++) begin
            if (pattern == 1)      src_mem[sel][k] = 16'((k + 1) * 16'h1111);
            else if (pattern == 2) src_mem[sel][k] = 16'hBEEF;
            else                   src_mem[sel][k] = 16'($urandom);
            exp_d.push_back(src_mem[sel][k]);
        end
        @(negedge clk);
        dst_base_in[sel] = base;
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        for (int c = 0; c < 2 * n + 8; c++) begin
            if (busy[sel]) begin nb++; last_busy = c; end
            if (done[sel]) begin nd++; done_at = c; if (busy[sel]) stray++; end
`ifdef SPRITE_DMA_CLEAR_EN
            if (src_wren[sel] && !busy[sel]) stray++;
`else
            if (src_wren[sel]) stray++;
`endif
            @(negedge clk);
        end
        chk("busy_cycles", 32'(nb), 32'(exp_busy));
        chk("done_pulses", 32'(nd), 32'd1);
        chk("done_after_busy", 32'(done_at), 32'(last_busy + 1));
        chk("stray_src_wren", 32'(stray), 32'd0);
        chk("write_count", 32'(wlog.size() - w0), 32'(n));
        if (wlog.size() - w0 == n) begin
            chk("first_addr", 32'(wlog[w0][25:16]), 32'(exp_first));
            chk("last_addr", 32'(wlog[w0 + n - 1][25:16]), 32'(exp_last));
            for (int k = 0; k < n; k++) begin
                chk("word_addr", 32'(wlog[w0 + k][25:16]), 32'(10'(base + 10'(k))));
                chk("word_data", 32'(wlog[w0 + k][15:0]), 32'(exp_d[k]));
            end
        end
        chk("clear_count", 32'(clog.size() - c0), 32'(clr_extra(n)));
        if (clog.size() - c0 == clr_extra(n)) begin
            for (int k = 0; k < clr_extra(n); k++)
                chk("clear_write", 32'(clog[c0 + k]), 32'({10'(k), 16'h0000}));
        end
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{0, 10'h010, 1, 10'h010, 10'h013, 5};
        vecs[1] = '{0, 10'h3FE, 1, 10'h3FE, 10'h001, 5};
        vecs[2] = '{0, 10'h3FC, 0, 10'h3FC, 10'h3FF, 5};
        vecs[3] = '{1, 10'h200, 2, 10'h200, 10'h200, 2};
        vecs[4] = '{1, 10'h3FF, 0, 10'h3FF, 10'h3FF, 2};

        for (int i = 0; i < 1024; i++) begin
            src_mem[0][i] = 16'($urandom);
            src_mem[1][i] = 16'($urandom);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("reset_outputs", 32'({busy[i], done[i], src_wren[i], dst_wren[i], src_addr[i], dst_addr[i]}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            xfer(vecs[i].sel, vecs[i].base, vecs[i].pattern, vecs[i].exp_first, vecs[i].exp_last,
                 vecs[i].exp_busy + clr_extra(vecs[i].sel == 0 ? 4 : 1));

        // Random transfers against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            logic [9:0] b;
            int s;
            b = 10'($urandom);
            s = (i % 4 == 3) ? 1 : 0;
            if (s == 0) xfer(0, b, 0, b, 10'(b + 10'd3), 5 + clr_extra(4));
            else        xfer(1, b, 0, b, b, 2 + clr_extra(1));
        end

        // start held high: one transfer per IDLE entry, pattern busy..done,idle repeating.
        begin
            int blen = 5 + clr_extra(4);
            int p = blen + 2;
            @(negedge clk);
            dst_base_in[0] = 10'h040;
            start[0] = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk("held_busy", 32'(busy[0]), 32'((c % p) < blen));
                chk("held_done", 32'(done[0]), 32'((c % p) == blen));
            end
            start[0] = 1'b0;
            repeat (16) @(negedge clk);
        end

        // Reset mid-transfer aborts with at most one write and no done.
        begin
            int w0;
            int nd = 0;
            w0 = wlog.size();
            dst_base_in[0] = 10'h080;
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("abort_outputs", 32'({busy[0], done[0], src_wren[0], dst_wren[0], dst_data[0]}), 32'd0);
            chk("abort_addrs", 32'({src_addr[0], dst_addr[0]}), 32'd0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done[0]) nd++;
            end
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done[0]) nd++;
            end
            chk("abort_no_done", 32'(nd), 32'd0);
            chk("abort_writes_le1", 32'(wlog.size() - w0 <= 1), 32'd1);
            xfer(0, 10'h123, 0, 10'h123, 10'h126, 5 + clr_extra(4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
